// File: rtl/intmul_rr_sched_pkg.sv
// intmul_rr_sched_pkg: shared constants, tag type and clog2 helper for the multiplier scheduler
package intmul_rr_sched_pkg;
    localparam int MUL_LAT = 5;
    localparam int TAG_IDW = 8;
    typedef struct packed {
        logic               valid;
        logic [TAG_IDW-1:0] id;
    } tag_t;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/intmul_rr_sched_arb.sv
// intmul_rr_sched_arb: pointer-based round-robin arbiter
//   valid : per-requester request
//   ptr   : highest-priority requester this cycle
//   grant : one-hot grant (zero when nobody requests)
//   id    : encoded index of the granted requester
module intmul_rr_sched_arb
    import intmul_rr_sched_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  id
);
    int idx;
    // Walk from the farthest offset down so the requester nearest the pointer wins last.
    always_comb begin
        grant = '0;
        id    = '0;
        idx   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (valid[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                id         = IDW'(idx);
            end
        end
    end
endmodule

// File: rtl/intmul_rr_sched.sv
// intmul_rr_sched: round-robin issue of operand pairs to a shared fixed-latency multiplier, products returned tagged
//   clk, rst            : clock, asynchronous active-high reset
//   req_valid/req_ready : per-requester handshake, req_ready one-hot or zero
//   req_A/req_B         : packed operands, requester i at [i*LOGA +: LOGA] / [i*LOGB +: LOGB]
//   mul_A/mul_B/mul_C   : registered operands to, and product from, the external multiplier
//   rsp_valid/rsp_id    : single-cycle product pulse and owning requester
//   rsp_C               : product (mirrors mul_C)
//   inflight            : operations issued and not yet returned
module intmul_rr_sched
    import intmul_rr_sched_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int LOGA = 34,
    parameter int LOGB = 43,
    parameter int LAT  = MUL_LAT,
    parameter int IDW  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*LOGA-1:0]       req_A,
    input  logic [NREQ*LOGB-1:0]       req_B,
    output logic [LOGA-1:0]            mul_A,
    output logic [LOGB-1:0]            mul_B,
    input  logic [LOGA+LOGB-1:0]       mul_C,
    output logic                       rsp_valid,
    output logic [IDW-1:0]             rsp_id,
    output logic [LOGA+LOGB-1:0]       rsp_C,
    output logic [clog2(LAT+2)-1:0]    inflight
);
    localparam int IFW = clog2(LAT + 2);
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  gid;
    logic [NREQ-1:0] grant;
    logic            hs;
    // tag[0] rides alongside mul_A; tag[1..LAT] track the multiplier's LAT stages so tag[LAT] lines up with mul_C.
    tag_t            tag [0:LAT];
    intmul_rr_sched_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .id    (gid)
    );
    assign req_ready = rst ? '0 : grant;
    assign hs        = |(req_valid & req_ready);
    assign rsp_valid = tag[LAT].valid;
    assign rsp_id    = tag[LAT].id[IDW-1:0];
    assign rsp_C     = mul_C;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_A    <= '0;
            mul_B    <= '0;
            ptr      <= '0;
            inflight <= '0;
            for (int k = 0; k <= LAT; k++) tag[k] <= '0;
        end else begin
            // Idle cycles drive zero operands to keep the multiplier quiet and deterministic.
            mul_A    <= hs ? req_A[gid*LOGA +: LOGA] : '0;
            mul_B    <= hs ? req_B[gid*LOGB +: LOGB] : '0;
            tag[0]   <= '{valid: hs, id: TAG_IDW'(gid)};
            for (int k = 1; k <= LAT; k++) tag[k] <= tag[k-1];
            if (hs) ptr <= (int'(gid) == NREQ - 1) ? '0 : gid + 1'b1;
            inflight <= inflight + IFW'(hs) - IFW'(rsp_valid);
        end
    end
endmodule
